secded_ecc_comb: RTL and testbench

Single-clock SECDED (single-error-correct, double-error-detect) ECC datapath protecting a 64-bit word with an extended Hamming(72,64) code. The datapath runs encoder, then an error-injection stage that XORs a mask onto the codeword, then decoder. It sits between a data producer and a storage or link model: the injection stage models channel noise, so benches can exercise correction and detection. Encode and decode logic is combinational; only the decoder outputs are registered.

---
 rtl/secded_ecc_comb_pkg.sv | 60 ++++++
 rtl/secded_ecc_comb_if.sv | 33 +++
 rtl/secded_ecc_comb_chk_gen.sv | 12 +
 rtl/secded_ecc_comb.sv | 93 +++++++++
 tb/tb_secded_ecc_comb.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/secded_ecc_comb_pkg.sv
// Shared constants and helpers for the extended Hamming(72,64) SECDED datapath.
// Maps data bits to Hamming positions and computes the seven check bits.
package secded_pkg;

    localparam int DATA_W = 64;
    localparam int CHK_W  = 7;
    localparam int CODE_W = DATA_W + CHK_W + 1;

    // Highest valid Hamming position; larger syndromes cannot come from one flipped bit.
    localparam logic [CHK_W-1:0] MAX_POS = CHK_W'(CODE_W - 1);

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_class_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              single_err;
        logic              double_err;
    } dec_result_t;

    // Packed table: slice k holds the Hamming position of data bit k.
    function automatic logic [DATA_W*CHK_W-1:0] build_pos_tbl();
        logic [DATA_W*CHK_W-1:0] tbl;
        int                      k;
        tbl = '0;
        k   = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                tbl[k*CHK_W +: CHK_W] = CHK_W'(p);
                k++;
            end
        end
        return tbl;
    endfunction

    localparam logic [DATA_W*CHK_W-1:0] POS_TBL = build_pos_tbl();

    function automatic logic [CHK_W-1:0] data_pos(input int k);
        return POS_TBL[k*CHK_W +: CHK_W];
    endfunction

    function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        logic [CHK_W-1:0] pos;
        c = '0;
        for (int k = 0; k < DATA_W; k++) begin
            pos = data_pos(k);
            for (int j = 0; j < CHK_W; j++) begin
                if (pos[j]) begin
                    c[j] = c[j] ^ d[k];
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/secded_ecc_comb_if.sv
// Data/codeword bundle between a word producer and the SECDED datapath.
// The producer drives the word and noise mask; the datapath returns codeword and decode.
interface secded_ecc_comb_if;

    logic [secded_pkg::DATA_W-1:0] data_in;
    logic [secded_pkg::CODE_W-1:0] err_mask;
    logic [secded_pkg::CODE_W-1:0] enc_out;
    logic [secded_pkg::CODE_W-1:0] data_out;
    logic                          error_detected;
    logic                          single_error;
    logic                          double_error;

    modport master (
        output data_in,
        output err_mask,
        input  enc_out,
        input  data_out,
        input  error_detected,
        input  single_error,
        input  double_error
    );

    modport slave (
        input  data_in,
        input  err_mask,
        output enc_out,
        output data_out,
        output error_detected,
        output single_error,
        output double_error
    );

endinterface

// File: rtl/secded_ecc_comb_chk_gen.sv
// Combinational Hamming check-bit generator over a 64-bit data word.
// Shared by the encoder and by the decoder's syndrome recomputation.
module secded_chk_gen
    import secded_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  chk
);

    assign chk = calc_chk(data);

endmodule

// File: rtl/secded_ecc_comb.sv
// SECDED datapath: encode, XOR a noise mask, decode/correct, register the result.
// Encode and decode are combinational; only the decoder outputs are registered.
module secded_ecc_comb #(
    parameter int DATA_W = 64,
    parameter int CODE_W = 72
) (
    input logic              clk,
    input logic              rst_n,
    secded_ecc_comb_if.slave bus
);

    import secded_pkg::*;

    logic [CHK_W-1:0]  enc_chk;
    logic [CHK_W-1:0]  rx_chk;
    logic [CHK_W-1:0]  syn;
    logic [CODE_W-1:0] enc_word;
    logic [CODE_W-1:0] rx_word;
    logic [CODE_W-1:0] corr_mask;
    logic              rx_par;
    err_class_t        err_class;
    dec_result_t       dec_d;
    dec_result_t       dec_q;

    // Encoder
    secded_chk_gen u_enc_chk (
        .data (bus.data_in),
        .chk  (enc_chk)
    );

    assign enc_word    = {^{bus.data_in, enc_chk}, enc_chk, bus.data_in};
    assign bus.enc_out = enc_word;

    // Channel noise, then syndrome and overall parity of the received word
    assign rx_word = enc_word ^ bus.err_mask;

    secded_chk_gen u_dec_chk (
        .data (rx_word[DATA_W-1:0]),
        .chk  (rx_chk)
    );

    assign syn    = rx_chk ^ rx_word[CODE_W-2:DATA_W];
    assign rx_par = ^rx_word;

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        corr_mask = '0;
        err_class = ERR_NONE;
        if (rx_par) begin
            if (syn == '0) begin
                corr_mask[CODE_W-1] = 1'b1;
                err_class           = ERR_SINGLE;
            end else if (syn <= MAX_POS) begin
                err_class = ERR_SINGLE;
                for (int k = 0; k < DATA_W; k++) begin
                    if (syn == data_pos(k)) begin
                        corr_mask[k] = 1'b1;
                    end
                end
                for (int j = 0; j < CHK_W; j++) begin
                    if (syn == CHK_W'(1 << j)) begin
                        corr_mask[DATA_W+j] = 1'b1;
                    end
                end
            end else begin
                err_class = ERR_DOUBLE;
            end
        end else if (syn != '0) begin
            err_class = ERR_DOUBLE;
        end
    end

    always_comb begin
        dec_d.code       = rx_word ^ corr_mask;
        dec_d.single_err = (err_class == ERR_SINGLE);
        dec_d.double_err = (err_class == ERR_DOUBLE);
    end

    // NOTE: reset is asynchronous and active-high despite the port name; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign bus.data_out       = dec_q.code;
    assign bus.single_error   = dec_q.single_err;
    assign bus.double_error   = dec_q.double_err;
    assign bus.error_detected = dec_q.single_err | dec_q.double_err;

endmodule

// File: tb/tb_secded_ecc_comb.sv
// Self-checking bench for secded_ecc_comb: directed cases plus randomized
// single/double-error sweeps against a position-based Hamming reference model.
module tb_secded_ecc_comb;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    secded_ecc_comb_if bus ();

    secded_ecc_comb #(
        .DATA_W (64),
        .CODE_W (72)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference encoder built from Hamming positions rather than a bit table.
    function automatic logic [71:0] model_encode(input logic [63:0] d);
        logic [71:1] h;
        logic [6:0]  c;
        int          k;
        h = '0;
        k = 0;
        for (int pos = 1; pos < 72; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                h[pos] = d[k];
                k++;
            end
        end
        c = '0;
        for (int j = 0; j < 7; j++) begin
            for (int pos = 1; pos < 72; pos++) begin
                if (((pos >> j) & 1) == 1) begin
                    c[j] = c[j] ^ h[pos];
                end
            end
        end
        return {^{c, d}, c, d};
    endfunction

    // Expected {data_out, error_detected, single_error, double_error} for 0/1/2-bit masks.
    function automatic logic [74:0] model_decode(input logic [63:0] d, input logic [71:0] m);
        logic [71:0] cw;
        cw = model_encode(d);
        case ($countones(m))
            0:       return {cw, 3'b000};
            1:       return {cw, 3'b110};
            default: return {cw ^ m, 3'b101};
        endcase
    endfunction

    function automatic logic [74:0] observed();
        return {bus.data_out, bus.error_detected, bus.single_error, bus.double_error};
    endfunction

    task automatic step(input logic [63:0] d, input logic [71:0] m);
        bus.data_in  = d;
        bus.err_mask = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b1;
        bus.data_in  = 64'hDEADBEEF_CAFECAFE;
        bus.err_mask = '0;
        #1;
        checks++;
        if (observed() !== 75'd0) begin
            errors++;
            $display("FAIL reset_immediate: got %h expected %h", observed(), 75'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== 75'd0) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", observed(), 75'd0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.data_out[63:0] !== 64'hDEADBEEF_CAFECAFE) begin
            errors++;
            $display("FAIL reset_release_data: got %h expected %h", bus.data_out[63:0], 64'hDEADBEEF_CAFECAFE);
        end
        checks++;
        if ({bus.error_detected, bus.single_error, bus.double_error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_flags: got %b expected 000",
                     {bus.error_detected, bus.single_error, bus.double_error});
        end
    endtask

    task automatic test_clean();
        step(64'h1, '0);
        checks++;
        if (bus.enc_out !== 72'h83_0000000000000001) begin
            errors++;
            $display("FAIL clean_enc_const: got %h expected %h", bus.enc_out, 72'h83_0000000000000001);
        end
        checks++;
        if (bus.enc_out !== model_encode(64'h1)) begin
            errors++;
            $display("FAIL clean_enc_model: got %h expected %h", bus.enc_out, model_encode(64'h1));
        end
        checks++;
        if (observed() !== {72'h83_0000000000000001, 3'b000}) begin
            errors++;
            $display("FAIL clean_decode: got %h expected %h", observed(), {72'h83_0000000000000001, 3'b000});
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] words [2];
        words[0] = 64'hDEADBEEF_CAFECAFE;
        words[1] = 64'h12345678_9ABCDEF0;
        for (int i = 0; i < 2; i++) begin
            step(words[i], '0);
            checks++;
            if (observed() !== model_decode(words[i], '0)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, observed(), model_decode(words[i], '0));
            end
        end
    endtask

    task automatic test_single();
        int          bits [3];
        logic [71:0] m;
        bits[0] = 5;
        bits[1] = 66;
        bits[2] = 71;
        for (int i = 0; i < 3; i++) begin
            m = 72'd1 << bits[i];
            step(64'hDEADBEEF_CAFECAFE, m);
            checks++;
            if (observed() !== {model_encode(64'hDEADBEEF_CAFECAFE), 3'b110}) begin
                errors++;
                $display("FAIL single_bit%0d: got %h expected %h", bits[i], observed(),
                         {model_encode(64'hDEADBEEF_CAFECAFE), 3'b110});
            end
        end
    endtask

    task automatic test_double();
        step(64'hDEADBEEF_CAFECAFE, 72'h3);
        checks++;
        if ({bus.single_error, bus.double_error, bus.error_detected} !== 3'b011) begin
            errors++;
            $display("FAIL double_flags: got %b expected 011",
                     {bus.single_error, bus.double_error, bus.error_detected});
        end
        checks++;
        if (bus.data_out[63:0] !== 64'hDEADBEEF_CAFECAFD) begin
            errors++;
            $display("FAIL double_data: got %h expected %h", bus.data_out[63:0], 64'hDEADBEEF_CAFECAFD);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] d;
        logic [71:0] m;
        int          a;
        int          b;
        for (int i = 0; i < 72; i++) begin
            d = {$urandom, $urandom};
            m = 72'd1 << i;
            step(d, m);
            checks++;
            if (observed() !== model_decode(d, m) || bus.enc_out !== model_encode(d)) begin
                errors++;
                $display("FAIL sweep_single bit %0d: got %h expected %h", i, observed(), model_decode(d, m));
            end
        end
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom};
            a = int'($urandom_range(71, 0));
            b = int'($urandom_range(70, 0));
            if (b >= a) b++;
            m = (72'd1 << a) | (72'd1 << b);
            step(d, m);
            checks++;
            if (observed() !== model_decode(d, m)) begin
                errors++;
                $display("FAIL sweep_double bits %0d,%0d: got %h expected %h", a, b, observed(), model_decode(d, m));
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] d;
        d = 64'h0F1E2D3C_4B5A6978;
        step(d, '0);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (observed() !== 75'd0) begin
            errors++;
            $display("FAIL midreset_clear: got %h expected %h", observed(), 75'd0);
        end
        checks++;
        if (bus.enc_out !== model_encode(d)) begin
            errors++;
            $display("FAIL midreset_enc: got %h expected %h", bus.enc_out, model_encode(d));
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== model_decode(d, '0)) begin
            errors++;
            $display("FAIL midreset_resume: got %h expected %h", observed(), model_decode(d, '0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean();
        test_back_to_back();
        test_single();
        test_double();
        test_sweep();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
